// File: rtl/tile_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tile_game_ctrl
// Purpose  : 4x4 tile-flip memory game controller (reveals, pair compare,
//            mismatch display timing, cursor and move tracking).
// Revision : 1.0
// ============================================================================
module tile_game_ctrl #(
  parameter int MISMATCH_HOLD = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_select,
  input  logic [63:0] tile_map,
  output logic [15:0] game_state,
  output logic [15:0] matched_tiles,
  output logic [15:0] mismatched_tiles,
  output logic [3:0]  cursor,
  output logic [7:0]  moves,
  output logic        game_over
);

  localparam int        TW     = $clog2(MISMATCH_HOLD + 1);
  localparam logic [TW-1:0] C_LOAD = TW'(MISMATCH_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FIRST   = 3'd1,
    SECOND  = 3'd2,
    COMPARE = 3'd3,
    SHOW    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [63:0]     map_q, map_d;
  logic [15:0]     gs_q, gs_d;
  logic [15:0]     matched_q, matched_d;
  logic [15:0]     mism_q, mism_d;
  logic [3:0]      cursor_q, cursor_d;
  logic [7:0]      moves_q, moves_d;
  logic            over_q, over_d;
  logic [3:0]      first_q, first_d;
  logic [3:0]      second_q, second_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [5:0]      w_first_base;
  logic [5:0]      w_second_base;
  logic [15:0]     w_pair_mask;
  logic            w_sel_valid;
  logic            w_move_ok;
  logic [1:0]      w_row;
  logic [1:0]      w_col;

  assign w_first_base  = {first_q, 2'b00};
  assign w_second_base = {second_q, 2'b00};
  assign w_pair_mask   = (16'd1 << first_q) | (16'd1 << second_q);
  assign w_sel_valid   = btn_select && !gs_q[cursor_q];
  assign w_move_ok     = (state_q != IDLE);
  assign w_row         = cursor_q[3:2];
  assign w_col         = cursor_q[1:0];

  always_comb begin
    state_d   = state_q;
    map_d     = map_q;
    gs_d      = gs_q;
    matched_d = matched_q;
    mism_d    = mism_q;
    cursor_d  = cursor_q;
    moves_d   = moves_q;
    over_d    = over_q;
    first_d   = first_q;
    second_d  = second_q;
    timer_d   = timer_q;

    if (new_game) begin
      map_d     = tile_map;
      gs_d      = 16'h0000;
      matched_d = 16'h0000;
      mism_d    = 16'h0000;
      cursor_d  = 4'd0;
      moves_d   = 8'd0;
      over_d    = 1'b0;
      timer_d   = '0;
      state_d   = FIRST;
    end else begin
      // Only one move per cycle; selects below still use cursor_q.
      if (w_move_ok) begin
        if (btn_up)         cursor_d = {w_row - 2'd1, w_col};
        else if (btn_down)  cursor_d = {w_row + 2'd1, w_col};
        else if (btn_left)  cursor_d = {w_row, w_col - 2'd1};
        else if (btn_right) cursor_d = {w_row, w_col + 2'd1};
      end

      case (state_q)
        FIRST: begin
          if (w_sel_valid) begin
            gs_d[cursor_q] = 1'b1;
            first_d        = cursor_q;
            state_d        = SECOND;
          end
        end
        SECOND: begin
          if (w_sel_valid) begin
            gs_d[cursor_q] = 1'b1;
            second_d       = cursor_q;
            moves_d        = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
            state_d        = COMPARE;
          end
        end
        COMPARE: begin
          if (map_q[w_first_base +: 4] == map_q[w_second_base +: 4]) begin
            matched_d = matched_q | w_pair_mask;
            if (matched_d == 16'hFFFF) begin
              over_d  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = FIRST;
            end
          end else begin
            mism_d  = mism_q | w_pair_mask;
            timer_d = C_LOAD;
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (timer_q == '0) begin
            gs_d    = gs_q & ~w_pair_mask;
            mism_d  = mism_q & ~w_pair_mask;
            state_d = FIRST;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      map_q     <= 64'd0;
      gs_q      <= 16'h0000;
      matched_q <= 16'h0000;
      mism_q    <= 16'h0000;
      cursor_q  <= 4'd0;
      moves_q   <= 8'd0;
      over_q    <= 1'b0;
      first_q   <= 4'd0;
      second_q  <= 4'd0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      map_q     <= map_d;
      gs_q      <= gs_d;
      matched_q <= matched_d;
      mism_q    <= mism_d;
      cursor_q  <= cursor_d;
      moves_q   <= moves_d;
      over_q    <= over_d;
      first_q   <= first_d;
      second_q  <= second_d;
      timer_q   <= timer_d;
    end
  end

  assign game_state       = gs_q;
  assign matched_tiles    = matched_q;
  assign mismatched_tiles = mism_q;
  assign cursor           = cursor_q;
  assign moves            = moves_q;
  assign game_over        = over_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_game_ctrl
// Purpose  : Directed scoreboard bench for tile_game_ctrl (hold = 4 cycles).
// Revision : 1.0
// ============================================================================
module tb_tile_game_ctrl;

  localparam int HOLD = 4;

  logic        clk;
  logic        reset;
  logic        new_game;
  logic        btn_up, btn_down, btn_left, btn_right, btn_select;
  logic [63:0] tile_map;
  logic [15:0] game_state, matched_tiles, mismatched_tiles;
  logic [3:0]  cursor;
  logic [7:0]  moves;
  logic        game_over;

  tile_game_ctrl #(.MISMATCH_HOLD(HOLD)) dut (
    .clk              (clk),
    .reset            (reset),
    .new_game         (new_game),
    .btn_up           (btn_up),
    .btn_down         (btn_down),
    .btn_left         (btn_left),
    .btn_right        (btn_right),
    .btn_select       (btn_select),
    .tile_map         (tile_map),
    .game_state       (game_state),
    .matched_tiles    (matched_tiles),
    .mismatched_tiles (mismatched_tiles),
    .cursor           (cursor),
    .moves            (moves),
    .game_over        (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_GS = 0, S_MT = 1, S_MM = 2, S_CUR = 3, S_MOV = 4, S_GO = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;
  logic [3:0] cur;

  function automatic logic [15:0] observe(int sel);
    case (sel)
      S_GS:    return game_state;
      S_MT:    return matched_tiles;
      S_MM:    return mismatched_tiles;
      S_CUR:   return {12'd0, cursor};
      S_MOV:   return {8'd0, moves};
      default: return {15'd0, game_over};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [15:0] e);
    exp_t x;
    x.tag = tag; x.sel = sel; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_all();
    exp_t        x;
    logic [15:0] o;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = observe(x.sel);
      vectors++;
      assert (o === x.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", x.tag, o, x.exp);
      end
    end
  endtask

  task automatic push_zero(input string tag);
    push({tag, ".gs"},  S_GS,  16'h0);
    push({tag, ".mt"},  S_MT,  16'h0);
    push({tag, ".mm"},  S_MM,  16'h0);
    push({tag, ".cur"}, S_CUR, 16'h0);
    push({tag, ".mov"}, S_MOV, 16'h0);
    push({tag, ".go"},  S_GO,  16'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    new_game = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_select = 0;
  endtask

  task automatic goto_tile(input logic [3:0] target);
    while (cur != target) begin
      if (cur[3:2] != target[3:2]) begin
        btn_down = 1;
        cur = {cur[3:2] + 2'd1, cur[1:0]};
      end else begin
        btn_right = 1;
        cur = {cur[3:2], cur[1:0] + 2'd1};
      end
      tick();
    end
  endtask

  initial begin
    logic [31:0] acc;
    vectors = 0; miscompares = 0; cur = 4'd0;
    new_game = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_select = 0;
    tile_map = 64'h7766554433221100;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    push_zero("reset");
    check_all();
    @(negedge clk);
    reset = 0;
    tick();

    // Select and move while IDLE: nothing changes.
    btn_select = 1; btn_right = 1;
    tick();
    push("idle_sel.gs", S_GS, 16'h0000);
    push("idle_sel.mov", S_MOV, 16'h0000);
    push("idle_sel.cur", S_CUR, 16'h0000);
    check_all();

    // Matching pair 0/1.
    new_game = 1;
    tick();
    push_zero("ng1");
    check_all();
    btn_select = 1;
    tick();
    push("m01.first", S_GS, 16'h0001);
    check_all();
    btn_right = 1;
    tick();
    push("m01.cur", S_CUR, 16'h0001);
    check_all();
    btn_select = 1;
    tick();
    push("m01.gs", S_GS, 16'h0003);
    push("m01.mov", S_MOV, 16'd1);
    push("m01.mt_pre", S_MT, 16'h0000);
    check_all();
    tick();
    push("m01.mt", S_MT, 16'h0003);
    push("m01.mm", S_MM, 16'h0000);
    check_all();

    // Mismatch 0/2 with a 4-cycle hold; select+move in one cycle uses old cursor.
    new_game = 1;
    tick(); cur = 4'd0;
    push_zero("ng2");
    check_all();
    btn_select = 1; btn_right = 1;
    tick();
    push("mm.sel_move.gs", S_GS, 16'h0001);
    push("mm.sel_move.cur", S_CUR, 16'h0001);
    check_all();
    btn_right = 1;
    tick();
    btn_select = 1;
    tick();
    push("mm.gs", S_GS, 16'h0005);
    push("mm.mov", S_MOV, 16'd1);
    push("mm.pre", S_MM, 16'h0000);
    check_all();
    btn_right = 1;
    tick();
    push("mm.cur_compare", S_CUR, 16'h0003);
    for (int c = 1; c <= HOLD; c++) begin
      push($sformatf("mm.hold%0d", c), S_MM, 16'h0005);
      push($sformatf("mm.hold%0d.gs", c), S_GS, 16'h0005);
      check_all();
      if (c == 1) btn_select = 1;
      tick();
    end
    push("mm.clr", S_MM, 16'h0000);
    push("mm.clr.gs", S_GS, 16'h0000);
    push("mm.clr.mov", S_MOV, 16'd1);
    check_all();

    // Re-selecting the first pick and a matched tile are ignored.
    btn_select = 1;
    tick();
    push("re.first", S_GS, 16'h0008);
    check_all();
    btn_select = 1;
    tick();
    push("re.same.gs", S_GS, 16'h0008);
    push("re.same.mov", S_MOV, 16'd1);
    check_all();
    btn_left = 1;
    tick();
    btn_select = 1;
    tick();
    push("re.second.gs", S_GS, 16'h000C);
    push("re.second.mov", S_MOV, 16'd2);
    check_all();
    tick();
    push("re.mt", S_MT, 16'h000C);
    check_all();
    btn_select = 1;
    tick();
    push("re.matched.gs", S_GS, 16'h000C);
    push("re.matched.mov", S_MOV, 16'd2);
    check_all();

    // Full game: all 8 pairs.
    new_game = 1;
    tick(); cur = 4'd0;
    for (int t = 0; t < 16; t++) begin
      goto_tile(4'(t));
      btn_select = 1;
      tick();
      acc = (32'd1 << (t + 1)) - 32'd1;
      push($sformatf("full.gs%0d", t), S_GS, acc[15:0]);
      if (t % 2 == 1) begin
        push($sformatf("full.mov%0d", t), S_MOV, 16'((t + 1) / 2));
        check_all();
        tick();
        push($sformatf("full.mt%0d", t), S_MT, acc[15:0]);
        push($sformatf("full.go%0d", t), S_GO, (t == 15) ? 16'd1 : 16'd0);
      end
      check_all();
    end
    btn_select = 1; btn_up = 1;
    tick(); cur = 4'd11;
    push("done.gs", S_GS, 16'hFFFF);
    push("done.mov", S_MOV, 16'd8);
    push("done.go", S_GO, 16'd1);
    push("done.cur", S_CUR, 16'd11);
    check_all();
    new_game = 1;
    tick(); cur = 4'd0;
    push_zero("ng_done");
    check_all();

    // Cursor wrap and priority.
    btn_left = 1;
    tick();
    push("cur.left", S_CUR, 16'd3);
    check_all();
    btn_up = 1;
    tick();
    push("cur.up", S_CUR, 16'd15);
    check_all();
    btn_up = 1; btn_left = 1;
    tick();
    push("cur.prio", S_CUR, 16'd11);
    check_all();

    // Async reset during SHOW.
    new_game = 1;
    tick();
    btn_select = 1; btn_right = 1;
    tick();
    btn_right = 1;
    tick();
    btn_select = 1;
    tick();
    tick();
    push("ar.mm", S_MM, 16'h0005);
    check_all();
    reset = 1;
    #2;
    push_zero("async_reset");
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tile_game_ctrl.md
# tile_game_ctrl

Game-logic controller for the 4x4 tile-flip memory game. It turns debounced button pulses into tile reveals and pair comparisons, and times the display of mismatched pairs. It sits directly upstream of the VGA driver and produces its `game_state`, `matched_tiles` and `mismatched_tiles` buses, plus cursor, move count and game-over status. Tile values come from an external 16x4-bit map that is latched at game start.

## Interface
- `MISMATCH_HOLD`, default 50_000_000: number of cycles a mismatched pair stays visible. Must be at least 1.
- `clk` input 1: system clock, which is also the pixel clock.
- `reset` input 1: asynchronous, active-high reset.
- `new_game` input 1: single-cycle pulse that starts a new game.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` input 1 each: single-cycle cursor-move pulses.
- `btn_select` input 1: single-cycle pulse that reveals the tile under the cursor.
- `tile_map` input 64: value of tile i is `tile_map[4i+3:4i]`. Sampled only on `new_game`.
- `game_state` output 16: bit i = 1 means tile i is face-up.
- `matched_tiles` output 16: bit i = 1 means tile i is permanently matched.
- `mismatched_tiles` output 16: bit i = 1 means tile i is part of the pair currently shown as mismatched.
- `cursor` output 4: cursor tile index, computed as row*4+col.
- `moves` output 8: number of completed pair attempts, saturating at 255.
- `game_over` output 1: high when all 16 tiles are matched.

## Operation
- States:
  - IDLE: the reset state.
  - FIRST: waiting for the first pick of a pair.
  - SECOND: waiting for the second pick.
  - COMPARE: one cycle, compares the two picks.
  - SHOW: mismatched pair is on screen.
  - DONE: game complete.
- Reset (async): state goes to IDLE and all outputs and internal registers go to 0.
- `new_game`, in any state:
  - Latch `tile_map`.
  - Clear `game_state`, `matched_tiles`, `mismatched_tiles`, `moves` and `game_over`.
  - Set `cursor` to 0 and go to FIRST.
  - `new_game` has priority over every other input in the same cycle.
- IDLE and DONE: `btn_select` is ignored. Cursor buttons still act in DONE only.
- A tile is valid for selection when its `game_state` bit is 0. Selecting a face-up or matched tile is ignored, with no state change.
- FIRST: a valid select sets `game_state[cursor]`, stores `first_idx`, and moves to SECOND.
- SECOND: a valid select does the following:
  - Sets `game_state[cursor]` and stores `second_idx`.
  - Increments `moves`, saturating at 255.
  - Moves to COMPARE.
  - Selecting the `first_idx` tile again is invalid, because its bit is already 1.
- COMPARE:
  - If the two tile values are equal: set both `matched_tiles` bits. If `matched_tiles` then equals 0xFFFF, set `game_over` and go to DONE; otherwise go to FIRST.
  - If the values differ: set both `mismatched_tiles` bits, load the hold timer with `MISMATCH_HOLD`-1, and go to SHOW.
- SHOW:
  - `btn_select` is ignored.
  - The timer decrements once per cycle.
  - In the cycle where the timer is 0: clear both the `game_state` and `mismatched_tiles` bits for the pair, then go to FIRST.
- Cursor movement:
  - Active in FIRST, SECOND, COMPARE, SHOW and DONE.
  - Up and down change the row modulo 4; left and right change the column modulo 4. Both wrap around.
  - If several move buttons pulse in one cycle, priority is up > down > left > right, and only one move is applied.
- Select and move in the same cycle: the select uses the cursor value from before the move.
- Hold timer width: $clog2(`MISMATCH_HOLD`+1).
- Tile comparison uses all 4 bits of each tile value.

## Timing
- A select pulse sampled at edge N appears on `game_state` after edge N; that is, it is visible in cycle N+1.
- Second pick sampled at edge N:
  - COMPARE occupies cycle N+1.
  - `matched_tiles` or `mismatched_tiles` updates after edge N+1.
- `mismatched_tiles` stays high for exactly `MISMATCH_HOLD` cycles. Its bits and the matching `game_state` bits clear on the same edge.
- `new_game` at edge N: all outputs reflect the cleared values in cycle N+1.
- `game_over` rises on the same edge as the final `matched_tiles` update.
- All outputs are registered, with no combinational paths from inputs to outputs.
- Async reset in any state, including mid-SHOW: outputs go to 0 immediately, without waiting for a clock edge.

## Test plan
- Reset, then `btn_select` before any `new_game` -> `game_state`=0x0000, `moves`=0, state stays IDLE.
- `new_game` with tile i value = i>>1 (`tile_map`=0x7766554433221100); select at 0, right, select -> `game_state`=0x0003 one cycle after the second select, `matched_tiles`=0x0003 one cycle later, `moves`=1.
- `MISMATCH_HOLD`=4; select tile 0, then tile 2 -> `mismatched_tiles`=0x0005 for exactly 4 cycles, then `game_state`=0x0000 and `mismatched_tiles`=0x0000; a select during SHOW has no effect.
- Select tile 0, then select tile 0 again; also select an already-matched tile -> no change to `game_state`, `moves` or state.
- Match all 8 pairs -> `matched_tiles`=0xFFFF, `game_over`=1, `moves`=8; a select in DONE is ignored; `new_game` -> all cleared, `cursor`=0.
- Cursor and reset:
  - From `cursor` 0, left -> 3, then up -> 15.
  - Up and left in the same cycle -> only up is applied.
  - Async reset asserted mid-SHOW -> all outputs 0 before the next clock edge.
